alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: ALU_LAT, default 1, number of cycles from operands driven to a valid ALU result (legal range 1..15).
REQ-002 Clock and reset: one clock; reset is synchronous and active-high. Ports are iClk and iRst.
REQ-003 iClk  input  1  rising-edge clock for all state.
REQ-004 iRst  input  1  synchronous, active-high reset.
REQ-005 iValid0 / iValid1  input  1  requester n has an operation pending.
REQ-006 iA0 / iA1, iB0 / iB1  input  4  operands of requester n.
REQ-007 iOp0 / iOp1  input  5  opcode of requester n; codes 0..16 are legal.
REQ-008 oReady0 / oReady1  output  1  one-cycle accept pulse; the request is taken on that cycle.
REQ-009 oDone0 / oDone1  output  1  one-cycle completion pulse to requester n.
REQ-010 oResp  output  4  result; valid while any oDone is high.
REQ-011 oFlags  output  5  ALU flags; valid while any oDone is high.
REQ-012 oErr  output  1  illegal opcode indication; valid while any oDone is high.
REQ-013 oBusy  output  1  high in every state except IDLE.
REQ-014 oAluA, oAluB  output  4  operands driven to the shared ALU.
REQ-015 oAluOp  output  5  opcode driven to the shared ALU.
REQ-016 iAluResp  input  4  ALU registered result.
REQ-017 iAluFlags  input  5  ALU registered flags.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, DONE.
REQ-019 In IDLE with at least one iValid high, the block SHALL grant one requester, pulse its oReady combinationally in that cycle, and latch its A, B and Op.
REQ-020 Grant SHALL be round-robin: a 1-bit priority pointer selects the favoured requester; on a tie the favoured one wins.
REQ-021 If only one iValid is high, that requester SHALL win regardless of the pointer.
REQ-022 The pointer SHALL move to the non-winner on the cycle oDone pulses.
REQ-023 oReady SHALL be asserted only in IDLE, to at most one requester per cycle.
REQ-024 A requester SHALL hold iValid and its operands until it sees oReady; the arbiter SHALL ignore operand changes after the accept cycle.
REQ-025 Legal op: IDLE -> ISSUE. From the ISSUE cycle until capture, oAluA/oAluB/oAluOp SHALL hold the latched values.
REQ-026 ISSUE -> WAIT unconditionally. The WAIT counter SHALL load ALU_LAT-1.
REQ-027 In WAIT, the counter SHALL decrement each cycle. On the cycle it equals 0, the block SHALL capture iAluResp and iAluFlags and move to DONE.
REQ-028 In DONE, the block SHALL pulse oDone of the granted requester for exactly one cycle, drive the captured oResp/oFlags with oErr=0, then return to IDLE.
REQ-029 Accept-to-done latency SHALL be ALU_LAT+2 cycles; with ALU_LAT=1, accept at T gives oDone at T+3.
REQ-030 Illegal op (iOp > 16): IDLE -> DONE directly with no ALU issue. oDone SHALL pulse at T+1 with oResp=0, oFlags=0 and oErr=1.
REQ-031 When no operation is in flight, oAluA/oAluB/oAluOp SHALL be 0.
REQ-032 When oDone is low, oResp, oFlags and oErr SHALL be 0.
REQ-033 Back-to-back requests: the earliest next accept SHALL be the cycle after DONE. There is no pipelining; one operation is in flight at most.
REQ-034 The non-granted requester SHALL receive no oReady or oDone and SHALL keep waiting.

Reset
REQ-035 On iRst high at a rising edge: state=IDLE, pointer=0 (requester 0 favoured), counter=0, latched operands=0.
REQ-036 During reset, all outputs SHALL be 0.
REQ-037 Reset mid-operation (ISSUE, WAIT or DONE) SHALL abort the operation: no oDone pulse for it, and the captured result is discarded.
REQ-038 iRst SHALL take priority over every transition in the same cycle.
REQ-039 The first cycle after iRst deasserts SHALL be IDLE, able to accept.

Verification
REQ-040 Single request, ALU_LAT=1, with a behavioural ALU model: iValid0 with A=5, B=3, Op=12 -> oReady0 at T; oAluA=5, oAluB=3, oAluOp=12 at T+1..T+2; oDone0 at T+3 with oResp=8.
REQ-041 Simultaneous iValid0/iValid1 after reset -> requester 0 served first. Requester 1 (A=9, B=4, Op=13) gets oReady1 the cycle after oDone0, and oResp=5 at its oDone1.
REQ-042 Both requesters held valid continuously for 4 operations -> grants alternate 0,1,0,1 and never overlap.
REQ-043 Illegal op: iValid1 with Op=20 -> oReady1 at T; oDone1 at T+1 with oErr=1 and oResp=0; oAluOp stays 0 throughout.
REQ-044 Reset in WAIT: iRst pulsed at T+2 of an accepted request -> no oDone; oBusy=0 the next cycle; a new request is accepted afterwards.
REQ-045 ALU_LAT=3: accept at T -> operands held T+1..T+4; oDone at T+5.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Requester, result and shared-ALU signals between two requesters and alu_arbiter.
// slave is the arbiter's view; master is the requester/ALU side.
interface alu_arbiter_if;
    logic       iValid0, iValid1;
    logic [3:0] iA0, iA1, iB0, iB1;
    logic [4:0] iOp0, iOp1;
    logic       oReady0, oReady1;
    logic       oDone0, oDone1;
    logic [3:0] oResp;
    logic [4:0] oFlags;
    logic       oErr;
    logic       oBusy;
    logic [3:0] oAluA, oAluB;
    logic [4:0] oAluOp;
    logic [3:0] iAluResp;
    logic [4:0] iAluFlags;

    modport slave (
        input  iValid0, iValid1, iA0, iA1, iB0, iB1, iOp0, iOp1, iAluResp, iAluFlags,
        output oReady0, oReady1, oDone0, oDone1, oResp, oFlags, oErr, oBusy,
               oAluA, oAluB, oAluOp
    );

    modport master (
        output iValid0, iValid1, iA0, iA1, iB0, iB1, iOp0, iOp1, iAluResp, iAluFlags,
        input  oReady0, oReady1, oDone0, oDone1, oResp, oFlags, oErr, oBusy,
               oAluA, oAluB, oAluOp
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter letting two requesters share one registered ALU,
// one operation in flight at a time.
module alu_arbiter #(
    parameter int ALU_LAT = 1
) (
    input  logic          iClk,
    input  logic          iRst,
    alu_arbiter_if.slave  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0] state_q, state_d;
    logic       ptr_q, ptr_d;
    logic       gnt_q, gnt_d;
    logic [3:0] a_q, a_d, b_q, b_d;
    logic [4:0] op_q, op_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] resp_q, resp_d;
    logic [4:0] flags_q, flags_d;
    logic       err_q, err_d;

    logic       req_any, win;
    logic [3:0] win_a, win_b;
    logic [4:0] win_op;
    logic       accept, run, done;

    // Pointer only breaks ties; a lone requester always wins.
    always_comb begin
        req_any = bus.iValid0 | bus.iValid1;
        win     = (bus.iValid0 && bus.iValid1) ? ptr_q : bus.iValid1;
        win_a   = win ? bus.iA1  : bus.iA0;
        win_b   = win ? bus.iB1  : bus.iB0;
        win_op  = win ? bus.iOp1 : bus.iOp0;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;
        flags_d = flags_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    gnt_d = win;
                    a_d   = win_a;
                    b_d   = win_b;
                    op_d  = win_op;
                    if (win_op > 5'd16) begin
                        err_d   = 1'b1;
                        resp_d  = '0;
                        flags_d = '0;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = 4'(ALU_LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    resp_d  = bus.iAluResp;
                    flags_d = bus.iAluFlags;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                ptr_d   = ~gnt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            gnt_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            resp_q  <= '0;
            flags_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            flags_q <= flags_d;
            err_q   <= err_d;
        end
    end

    // Every output is forced low while reset is held, even mid-operation.
    assign accept = !iRst && (state_q == IDLE) && req_any;
    assign run    = !iRst && ((state_q == ISSUE) || (state_q == WAIT));
    assign done   = !iRst && (state_q == DONE);

    assign bus.oReady0 = accept && !win;
    assign bus.oReady1 = accept && win;
    assign bus.oDone0  = done && !gnt_q;
    assign bus.oDone1  = done && gnt_q;
    assign bus.oResp   = done ? resp_q  : '0;
    assign bus.oFlags  = done ? flags_q : '0;
    assign bus.oErr    = done && err_q;
    assign bus.oBusy   = !iRst && (state_q != IDLE);
    assign bus.oAluA   = run ? a_q  : '0;
    assign bus.oAluB   = run ? b_q  : '0;
    assign bus.oAluOp  = run ? op_q : '0;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: ALU_LAT=1 and ALU_LAT=3 instances, each
// fed by a behavioural registered ALU; stimulus queues expected completions.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_arbiter_if b1 ();
    alu_arbiter_if b3 ();

    alu_arbiter #(.ALU_LAT(1)) dut1 (.iClk(clk), .iRst(rst), .bus(b1.slave));
    alu_arbiter #(.ALU_LAT(3)) dut3 (.iClk(clk), .iRst(rst), .bus(b3.slave));

    // Behavioural ALU: op 0 and, 1 or, 2 xor, 12 add, 13 sub, others pass A.
    // Flags: bit1 carry/borrow, bit0 zero.
    function automatic logic [8:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [4:0] op);
        logic [4:0] s;
        case (op)
            5'd0:    s = {1'b0, a & b};
            5'd1:    s = {1'b0, a | b};
            5'd2:    s = {1'b0, a ^ b};
            5'd12:   s = {1'b0, a} + {1'b0, b};
            5'd13:   s = {1'b0, a} - {1'b0, b};
            default: s = {1'b0, a};
        endcase
        return {3'b000, s[4], (s[3:0] == 4'd0), s[3:0]};
    endfunction

    logic [8:0] p1;
    logic [8:0] p3 [3];
    always @(posedge clk) begin
        p1    <= alu_f(b1.oAluA, b1.oAluB, b1.oAluOp);
        p3[0] <= alu_f(b3.oAluA, b3.oAluB, b3.oAluOp);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign b1.iAluResp  = p1[3:0];
    assign b1.iAluFlags = p1[8:4];
    assign b3.iAluResp  = p3[2][3:0];
    assign b3.iAluFlags = p3[2][8:4];

    typedef struct {
        int         who;
        logic [3:0] resp;
        logic [4:0] flags;
        logic       err;
        int         at;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];
    exp_t e1, e3;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    endtask

    // Monitors: pop and compare on every completion pulse; idle result bus must be 0.
    always @(negedge clk) begin
        if (b1.oDone0 || b1.oDone1) begin
            if (q1.size() == 0) begin
                total++;
                $display("FAIL d1 unexpected done: done0=%0b done1=%0b (cycle %0d)",
                         b1.oDone0, b1.oDone1, cyc);
            end else begin
                e1 = q1.pop_front();
                chk("d1 done who", 32'(b1.oDone1), 32'(e1.who));
                chk("d1 done single", 32'(b1.oDone0 & b1.oDone1), 32'd0);
                chk("d1 resp", 32'(b1.oResp), 32'(e1.resp));
                chk("d1 flags", 32'(b1.oFlags), 32'(e1.flags));
                chk("d1 err", 32'(b1.oErr), 32'(e1.err));
                chk("d1 done cycle", 32'(cyc), 32'(e1.at));
            end
        end else begin
            chk("d1 idle result bus", {22'd0, b1.oErr, b1.oFlags, b1.oResp}, 32'd0);
        end
    end

    always @(negedge clk) begin
        if (b3.oDone0 || b3.oDone1) begin
            if (q3.size() == 0) begin
                total++;
                $display("FAIL d3 unexpected done: done0=%0b done1=%0b (cycle %0d)",
                         b3.oDone0, b3.oDone1, cyc);
            end else begin
                e3 = q3.pop_front();
                chk("d3 done who", 32'(b3.oDone1), 32'(e3.who));
                chk("d3 resp", 32'(b3.oResp), 32'(e3.resp));
                chk("d3 flags", 32'(b3.oFlags), 32'(e3.flags));
                chk("d3 err", 32'(b3.oErr), 32'(e3.err));
                chk("d3 done cycle", 32'(cyc), 32'(e3.at));
            end
        end
    end

    task automatic issue(input int who, input logic [3:0] a, input logic [3:0] b,
                         input logic [4:0] op, input logic [3:0] r, input logic [4:0] f,
                         input logic e, input bit push, output int t);
        @(posedge clk); #1;
        if (who == 0) begin b1.iValid0 = 1; b1.iA0 = a; b1.iB0 = b; b1.iOp0 = op; end
        else          begin b1.iValid1 = 1; b1.iA1 = a; b1.iB1 = b; b1.iOp1 = op; end
        t = -1;
        for (int n = 0; n < 40 && t < 0; n++) begin
            @(negedge clk);
            if ((who == 0) ? b1.oReady0 : b1.oReady1) begin
                t = cyc;
                chk("no ready to other", 32'((who == 0) ? b1.oReady1 : b1.oReady0), 32'd0);
            end
        end
        if (t < 0) begin
            total++;
            $display("FAIL accept timeout req%0d: no oReady within 40 cycles", who);
        end else if (push) begin
            q1.push_back('{who, r, f, e, t + (e ? 1 : 3)});
        end
        @(posedge clk); #1;
        // Operands scrambled after accept: the arbiter must have latched them.
        if (who == 0) begin b1.iValid0 = 0; b1.iA0 = 4'hf; b1.iB0 = 4'hf; b1.iOp0 = 5'd0; end
        else          begin b1.iValid1 = 0; b1.iA1 = 4'hf; b1.iB1 = 4'hf; b1.iOp1 = 5'd0; end
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (!b1.oBusy && !b3.oBusy) ok = 1;
        end
        if (!ok) begin
            total++;
            $display("FAIL idle timeout: busy1=%0b busy3=%0b", b1.oBusy, b3.oBusy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, t4, g;
        b1.iValid0 = 1; b1.iValid1 = 0;
        b1.iA0 = 4'd5; b1.iB0 = 4'd5; b1.iOp0 = 5'd12;
        b1.iA1 = 0; b1.iB1 = 0; b1.iOp1 = 0;
        b3.iValid0 = 0; b3.iValid1 = 0;
        b3.iA0 = 0; b3.iB0 = 0; b3.iOp0 = 0;
        b3.iA1 = 0; b3.iB1 = 0; b3.iOp1 = 0;

        // Reset held with a request pending: every output must be 0.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst ready0", 32'(b1.oReady0), 32'd0);
        chk("rst busy", 32'(b1.oBusy), 32'd0);
        chk("rst done", 32'({b1.oDone0, b1.oDone1}), 32'd0);
        chk("rst alu bus", {19'd0, b1.oAluOp, b1.oAluB, b1.oAluA}, 32'd0);
        @(posedge clk); #1;
        rst = 0;
        b1.iValid0 = 0;

        // Simultaneous requests after reset: requester 0 first, 1 right after done0.
        @(posedge clk); #1;
        b1.iValid0 = 1; b1.iA0 = 4'd5; b1.iB0 = 4'd3; b1.iOp0 = 5'd12;
        b1.iValid1 = 1; b1.iA1 = 4'd9; b1.iB1 = 4'd4; b1.iOp1 = 5'd13;
        @(negedge clk);
        chk("tie ready0", 32'(b1.oReady0), 32'd1);
        chk("tie ready1", 32'(b1.oReady1), 32'd0);
        t = cyc;
        q1.push_back('{0, 4'd8, 5'd0, 1'b0, t + 3});
        @(posedge clk); #1;
        b1.iValid0 = 0; b1.iA0 = 4'hf; b1.iB0 = 4'hf; b1.iOp0 = 5'd0;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            chk("issue aluA", 32'(b1.oAluA), 32'd5);
            chk("issue aluB", 32'(b1.oAluB), 32'd3);
            chk("issue aluOp", 32'(b1.oAluOp), 32'd12);
            chk("issue busy", 32'(b1.oBusy), 32'd1);
            chk("waiting ready1", 32'(b1.oReady1), 32'd0);
        end
        @(negedge clk);
        chk("done-cycle ready1", 32'(b1.oReady1), 32'd0);
        chk("done-cycle alu idle", 32'(b1.oAluOp), 32'd0);
        @(negedge clk);
        chk("ready1 after done0", 32'(b1.oReady1), 32'd1);
        t4 = cyc;
        chk("ready1 cycle", 32'(t4), 32'(t + 4));
        q1.push_back('{1, 4'd5, 5'd0, 1'b0, t4 + 3});
        @(posedge clk); #1;
        b1.iValid1 = 0;
        wait_idle();

        // Both held valid for four operations: grants alternate 0,1,0,1.
        @(posedge clk); #1;
        b1.iValid0 = 1; b1.iA0 = 4'd9; b1.iB0 = 4'd7; b1.iOp0 = 5'd12;
        b1.iValid1 = 1; b1.iA1 = 4'd2; b1.iB1 = 4'd6; b1.iOp1 = 5'd2;
        g = 0;
        for (int n = 0; n < 80 && g < 4; n++) begin
            @(negedge clk);
            if (b1.oReady0 && b1.oReady1) begin
                total++;
                $display("FAIL grant overlap: ready0=1 ready1=1 (cycle %0d)", cyc);
            end else if (b1.oReady0 || b1.oReady1) begin
                chk("alternating grant", 32'(b1.oReady1), 32'(g % 2));
                if (b1.oReady1) q1.push_back('{1, 4'd4, 5'd0, 1'b0, cyc + 3});
                else            q1.push_back('{0, 4'd0, 5'd3, 1'b0, cyc + 3});
                g++;
            end
        end
        chk("four grants", 32'(g), 32'd4);
        @(posedge clk); #1;
        b1.iValid0 = 0; b1.iValid1 = 0;
        wait_idle();

        // Illegal ops and the legal boundary op 16.
        issue(1, 4'd3, 4'd3, 5'd20, 4'd0, 5'd0, 1'b1, 1, t);
        @(negedge clk);
        chk("illegal aluOp", 32'(b1.oAluOp), 32'd0);
        chk("illegal busy", 32'(b1.oBusy), 32'd1);
        wait_idle();
        issue(0, 4'd6, 4'd9, 5'd16, 4'd6, 5'd0, 1'b0, 1, t);
        wait_idle();
        issue(0, 4'd2, 4'd2, 5'd17, 4'd0, 5'd0, 1'b1, 1, t);
        wait_idle();

        // Reset during WAIT aborts silently; next request still served.
        issue(0, 4'd1, 4'd1, 5'd12, 4'd2, 5'd0, 1'b0, 0, t);
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        chk("mid-rst busy", 32'(b1.oBusy), 32'd0);
        chk("mid-rst alu bus", {19'd0, b1.oAluOp, b1.oAluB, b1.oAluA}, 32'd0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("post-rst busy", 32'(b1.oBusy), 32'd0);
        issue(1, 4'd4, 4'd4, 5'd12, 4'd8, 5'd0, 1'b0, 1, t);
        wait_idle();

        // ALU_LAT=3 instance: operands held four cycles, done at T+5.
        @(posedge clk); #1;
        b3.iValid0 = 1; b3.iA0 = 4'd7; b3.iB0 = 4'd8; b3.iOp0 = 5'd12;
        @(negedge clk);
        chk("d3 ready0", 32'(b3.oReady0), 32'd1);
        t = cyc;
        q3.push_back('{0, 4'd15, 5'd0, 1'b0, t + 5});
        @(posedge clk); #1;
        b3.iValid0 = 0; b3.iA0 = 4'd0; b3.iB0 = 4'd0; b3.iOp0 = 5'd0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("d3 held operands", {19'd0, b3.oAluOp, b3.oAluB, b3.oAluA},
                {19'd0, 5'd12, 4'd8, 4'd7});
        end
        @(negedge clk);
        chk("d3 done-cycle alu idle", 32'(b3.oAluOp), 32'd0);
        wait_idle();

        repeat (3) @(negedge clk);
        chk("d1 queue drained", 32'(q1.size()), 32'd0);
        chk("d3 queue drained", 32'(q3.size()), 32'd0);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
